// File: rtl/iob_native_mem_responder.sv
// Single-port word memory behind a valid/ready handshake with a fixed,
// parameterised response latency and per-byte write strobes.
module iob_native_mem_responder #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                busy
);
  localparam int N_BYTES = DATA_W / 8;
  localparam int IDX_W   = ADDR_W - 2;
  localparam int DEPTH   = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [N_BYTES-1:0]   wstrb_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 accept;
  logic                 enter_resp;
  logic [IDX_W-1:0]     txn_idx;
  logic [DATA_W-1:0]    txn_wdata;
  logic [N_BYTES-1:0]   txn_strb;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (valid) begin
        accept = 1'b1;
        if (LATENCY == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the commit edge is the accept edge, so the live
  // inputs stand in for the not-yet-captured registers.
  always_comb begin
    txn_idx   = accept ? addr[ADDR_W-1:2] : idx_q;
    txn_wdata = accept ? wdata : wdata_q;
    txn_strb  = accept ? wstrb : wstrb_q;
  end

  // Memory shares the reset block only so that no write can land while
  // reset is held; its contents are never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= addr[ADDR_W-1:2];
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (enter_resp) begin
        if (txn_strb == '0) rdata_q <= mem[txn_idx];
        for (int b = 0; b < N_BYTES; b++)
          if (txn_strb[b]) mem[txn_idx][b*8 +: 8] <= txn_wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Directed bench: three responders (latency 0, 3, 5) sharing address/data
// inputs and reset, each with its own valid.
module tb_iob_native_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid0, valid3, valid5;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata0, rdata3, rdata5;
  logic        ready0, ready3, ready5;
  logic        busy0, busy3, busy5;

  int checks = 0;
  int failures = 0;

  logic        r_rdy;
  logic [31:0] r_data;
  int          first_rdy, busy_cnt, rdy_cnt;
  logic [15:0] wide_addr;
  logic [31:0] exp_b2b [3];

  iob_native_mem_responder #(.ADDR_W(14), .DATA_W(32), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .valid(valid0), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata0), .ready(ready0), .busy(busy0));
  iob_native_mem_responder #(.ADDR_W(14), .DATA_W(32), .LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .valid(valid3), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata3), .ready(ready3), .busy(busy3));
  iob_native_mem_responder #(.ADDR_W(14), .DATA_W(32), .LATENCY(5)) u5 (
    .clk(clk), .reset(reset), .valid(valid5), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata5), .ready(ready5), .busy(busy5));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency-0 transaction: ready/rdata sampled in the cycle after acceptance.
  task automatic txn0(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    valid0 = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    valid0 = 1'b0;
    r_rdy  = ready0;
    r_data = rdata0;
    tick();
  endtask

  // Latency-3 transaction: valid drops and inputs are scrambled right after
  // acceptance; records which cycle ready appears and how long busy lasts.
  task automatic txn3(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    valid3 = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    valid3 = 1'b0; addr = 14'h3FFC; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    first_rdy = -1; busy_cnt = 0; rdy_cnt = 0; r_data = '0;
    for (int k = 0; k < 7; k++) begin
      if (busy3) busy_cnt++;
      if (ready3) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = k;
        r_data = rdata3;
      end
      tick();
    end
  endtask

  // Latency-5 transaction with a bounded wait for ready.
  task automatic txn5(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    valid5 = 1'b1; addr = a; wdata = d; wstrb = s;
    tick();
    valid5 = 1'b0;
    r_rdy = 1'b0; r_data = '0;
    for (int k = 0; k < 12 && !r_rdy; k++) begin
      if (ready5) begin
        r_rdy  = 1'b1;
        r_data = rdata5;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; valid0 = 1'b0; valid3 = 1'b0; valid5 = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    #2;
    chk("rst_ready", {31'b0, ready0}, 32'd0);
    chk("rst_busy",  {31'b0, busy0},  32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    #20 reset = 1'b1;

    // Full write then read, latency 0
    txn0(14'h1234, 32'hDEADBEEF, 4'hF);
    chk("l0_wr_ready", {31'b0, r_rdy}, 32'd1);
    chk("l0_wr_keeps_rdata", r_data, 32'd0);
    chk("l0_idle_after", {30'b0, ready0, busy0}, 32'd0);
    txn0(14'h1234, 32'h0, 4'h0);
    chk("l0_rd_ready", {31'b0, r_rdy}, 32'd1);
    chk("l0_rd_data", r_data, 32'hDEADBEEF);
    chk("l0_rdata_hold", rdata0, 32'hDEADBEEF);

    // Partial strobe on word 0x10; byte-offset bits of addr ignored
    txn0(14'h0010, 32'hDEADBEEF, 4'hF);
    txn0(14'h0010, 32'hCAFEEFAC, 4'h1);
    chk("strb_wr_keeps_rdata", r_data, 32'hDEADBEEF);
    txn0(14'h0013, 32'h0, 4'h0);
    chk("strb_rd_data", r_data, 32'hDEADBEAC);

    // Latency 3: ready in 4th busy cycle, valid dropped after acceptance
    txn3(14'h0040, 32'h12345678, 4'hF);
    chk("l3_wr_first_rdy", first_rdy, 32'd3);
    chk("l3_wr_busy_cnt", busy_cnt, 32'd4);
    chk("l3_wr_rdy_cnt", rdy_cnt, 32'd1);
    chk("l3_wr_keeps_rdata", r_data, 32'd0);
    txn3(14'h0040, 32'h0, 4'h0);
    chk("l3_rd_first_rdy", first_rdy, 32'd3);
    chk("l3_rd_busy_cnt", busy_cnt, 32'd4);
    chk("l3_rd_rdy_cnt", rdy_cnt, 32'd1);
    chk("l3_rd_data", r_data, 32'h12345678);

    // Back-to-back reads with valid held high
    exp_b2b[0] = 32'hAAAA0000; exp_b2b[1] = 32'hBBBB0004; exp_b2b[2] = 32'hCCCC0008;
    txn0(14'h0000, exp_b2b[0], 4'hF);
    txn0(14'h0004, exp_b2b[1], 4'hF);
    txn0(14'h0008, exp_b2b[2], 4'hF);
    valid0 = 1'b1; addr = 14'h0000; wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("b2b_ready_%0d", i), {31'b0, ready0}, {31'b0, (i % 2) == 0});
      if ((i % 2) == 0) begin
        chk($sformatf("b2b_data_%0d", i / 2), rdata0, exp_b2b[i / 2]);
        addr = 14'((i / 2 + 1) * 4);
      end
      if (i == 4) valid0 = 1'b0;
    end

    // Reset mid-write at latency 5
    txn5(14'h0020, 32'h11112222, 4'hF);
    chk("l5_wr_ready", {31'b0, r_rdy}, 32'd1);
    valid5 = 1'b1; addr = 14'h0020; wdata = 32'h55555555; wstrb = 4'hF;
    tick();
    valid5 = 1'b0;
    tick();
    chk("l5_busy_in_wait", {31'b0, busy5}, 32'd1);
    reset = 1'b0;
    #2;
    chk("l5_rst_busy", {31'b0, busy5}, 32'd0);
    chk("l5_rst_cnt", {28'b0, u5.cnt_q}, 32'd0);
    #2 reset = 1'b1;
    rdy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready5) rdy_cnt++;
    end
    chk("l5_no_ready_after_rst", rdy_cnt, 32'd0);
    txn5(14'h0020, 32'h0, 4'h0);
    chk("l5_rd_ready", {31'b0, r_rdy}, 32'd1);
    chk("l5_word_kept", r_data, 32'h11112222);

    // Memory survives reset
    txn0(14'h1234, 32'h0, 4'h0);
    chk("mem_kept_after_rst", r_data, 32'hDEADBEEF);

    // Address wrap: 0x4004 aliases word 0x0004
    wide_addr = 16'h4004;
    txn0(wide_addr[13:0], 32'h0A0B0C0D, 4'hF);
    txn0(14'h0004, 32'h0, 4'h0);
    chk("wrap_alias", r_data, 32'h0A0B0C0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iob_native_mem_responder.md
IOB_NATIVE_MEM_RESPONDER -- requirements
Module: iob_native_mem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 14, giving the byte-address width; memory depth is 2**(ADDR_W-2) words.
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the word width; N_BYTES = DATA_W/8.
REQ-003 The module SHALL have parameter LATENCY, default 0, range 0..15, giving the extra wait cycles before ready.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 valid  input  1  request present.
REQ-008 addr  input  ADDR_W  byte address; bits [1:0] are ignored.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 wstrb  input  N_BYTES  byte write enables; all-zero means read.
REQ-011 rdata  output  DATA_W  read data, valid only while ready=1.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high from the acceptance cycle through the ready cycle.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE with valid=1 at a rising edge, the request SHALL be accepted: addr word index, wdata and wstrb are captured into registers.
REQ-016 On acceptance, the FSM SHALL go to WAIT with a latency counter loaded to LATENCY; if LATENCY=0 it SHALL go directly to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle and move to RESP on the edge where it is 1.
REQ-018 In RESP, ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 Total latency SHALL be LATENCY+1 cycles: ready is high in the cycle LATENCY+1 edges after the accepting edge, so LATENCY=0 matches a one-cycle registered-ready memory.
REQ-020 Writes SHALL commit at the edge entering RESP, using only the bytes whose wstrb bit is 1; all other bytes are unchanged.
REQ-021 Reads SHALL latch rdata from the captured word at the edge entering RESP.
REQ-022 rdata SHALL hold its last value outside RESP; write cycles leave rdata unchanged.
REQ-023 Inputs SHALL be ignored in WAIT and RESP; captured values alone determine the transaction.
REQ-024 valid deasserting before ready SHALL NOT cancel the transaction; the write still commits and ready still pulses.
REQ-025 valid=1 in the cycle after ready SHALL be treated as a new request, accepted from IDLE; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-026 Address arithmetic SHALL be modulo depth: the word index is addr[ADDR_W-1:2], with no out-of-range error.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While reset=0, the FSM SHALL be forced to IDLE, with ready=0, busy=0, rdata=0 and the counter at 0, regardless of clk.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A reset asserted mid-transaction SHALL abort it: a write not yet at the RESP edge is not committed, and no ready pulse follows reset release.
REQ-031 The first acceptance SHALL occur at the first rising edge after reset returns to 1 with valid=1.

Verification
REQ-032 LATENCY=0: write addr=0x1234, wdata=0xDEADBEEF, wstrb=0xF, then read 0x1234 -> each ready pulses one cycle after acceptance, and the read returns rdata=0xDEADBEEF.
REQ-033 Partial strobe: with word 0x10 holding 0xDEADBEEF, write wdata=0xCAFEEFAC, wstrb=0x1 -> a read of 0x10 returns 0xDEADBEAC.
REQ-034 LATENCY=3: a read request -> ready is high exactly 4 edges after acceptance, busy is high for 4 cycles, and valid dropping after 1 cycle changes nothing.
REQ-035 Back-to-back: valid held high across 3 reads at 0x0, 0x4 and 0x8 with LATENCY=0 -> 3 ready pulses, each separated by one idle cycle, with correct data.
REQ-036 Reset mid-write: LATENCY=5, write 0x55555555 to 0x20, reset pulsed low in WAIT -> no ready pulse, and word 0x20 keeps its prior value.
REQ-037 Wrap: ADDR_W=14, write to 0x4004 -> the aliased word 0x0004 is updated.
